// File: rtl/systolic_pkg.sv
// Shared fixed-point definitions for the systolic array datapath.
package systolic_pkg;

  localparam int FIXED_POINT_WIDTH    = 16;
  localparam int FIXED_POINT_POSITION = 10;

  typedef logic signed [FIXED_POINT_WIDTH-1:0] fixed_t;

endpackage

// File: rtl/systolic_output_deskew_sync_fifo.sv
// sync_fifo: single-clock FIFO for the deskewed output vectors.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   push/push_data : write request; accepted when not full, or when full
//                    and a pop happens on the same edge
//   pop        : read request; ignored while empty
//   pop_data   : head entry, forced to zero while empty
//   full, empty, count : occupancy status (count ranges 0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    // A pop on the same edge frees the head slot, so a full FIFO can still push.
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew: realigns skewed systolic array column sums into
// whole result vectors and buffers them behind a valid/ready interface.
//   clk_in, rst_in   : rising-edge clock, asynchronous active-high reset
//   sum_in           : column sums, column c arriving c cycles after column 0
//   sum_valid_in     : marks the cycle column 0 of a vector is on sum_in
//   result_out       : aligned vector at FIFO head (zero when not valid)
//   result_valid_out / result_ready_in : output handshake
//   overflow_out     : sticky, set when an aligned vector found the FIFO full
//   count_out        : FIFO occupancy
// Build option: define SYSTOLIC_RELU_EN to clamp negative columns to zero
// before they enter the FIFO. SYSTOLIC_ARRAY_COLS must be at least 2.
module systolic_output_deskew
  import systolic_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_COLS = 8,
  parameter int FIXED_POINT_WIDTH   = systolic_pkg::FIXED_POINT_WIDTH,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                                                  clk_in,
  input  logic                                                  rst_in,
  input  logic [SYSTOLIC_ARRAY_COLS-1:0][FIXED_POINT_WIDTH-1:0] sum_in,
  input  logic                                                  sum_valid_in,
  output logic [SYSTOLIC_ARRAY_COLS-1:0][FIXED_POINT_WIDTH-1:0] result_out,
  output logic                                                  result_valid_out,
  input  logic                                                  result_ready_in,
  output logic                                                  overflow_out,
  output logic [$clog2(FIFO_DEPTH):0]                           count_out
);

  localparam int COLS = SYSTOLIC_ARRAY_COLS;
  localparam int W    = FIXED_POINT_WIDTH;

  logic [COLS-1:0][W-1:0] aligned;
  logic [COLS-1:0][W-1:0] wr_data;
  logic [COLS-2:0]        vld_q, vld_d;
  logic                   aligned_vld;
  logic                   overflow_q, overflow_d;
  logic                   fifo_full, fifo_empty;

  // Column c needs COLS-1-c stages to line up with the last column, which
  // arrives latest and feeds the alignment point directly.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned[c] = sum_in[c];
    end else begin : g_dly
      logic [D-1:0][W-1:0] sr_q, sr_d;
      always_comb begin
        sr_d[0] = sum_in[c];
        for (int unsigned i = 1; i < D; i++) sr_d[i] = sr_q[i-1];
      end
      always_ff @(posedge clk_in) begin
        sr_q <= sr_d;
      end
      assign aligned[c] = sr_q[D-1];
    end
  end

  always_comb begin
    vld_d[0] = sum_valid_in;
    for (int unsigned i = 1; i < COLS - 1; i++) vld_d[i] = vld_q[i-1];
  end

  assign aligned_vld = vld_q[COLS-2];

  always_comb begin
`ifdef SYSTOLIC_RELU_EN
    for (int unsigned c = 0; c < COLS; c++) begin
      wr_data[c] = aligned[c][W-1] ? '0 : aligned[c];
    end
`else
    wr_data = aligned;
`endif
  end

  // Full implies non-empty, so a pop on this edge is exactly result_ready_in.
  always_comb begin
    overflow_d = overflow_q | (aligned_vld && fifo_full && !result_ready_in);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (COLS * W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (aligned_vld),
    .push_data (wr_data),
    .pop       (result_ready_in),
    .pop_data  (result_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count_out)
  );

  assign result_valid_out = !fifo_empty;
  assign overflow_out     = overflow_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
module tb_systolic_output_deskew;
  import systolic_pkg::*;

  localparam int COLS  = 8;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef logic [COLS-1:0][W-1:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_in;
  vec_t        sum_in;
  logic        sum_valid_in;
  vec_t        result_out;
  logic        result_valid_out;
  logic        result_ready_in;
  logic        overflow_out;
  logic [CW-1:0] count_out;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vec_tab [5];
  vec_t exp_q   [4];

  always #5 clk = ~clk;

  systolic_output_deskew #(
    .SYSTOLIC_ARRAY_COLS (COLS),
    .FIXED_POINT_WIDTH   (W),
    .FIFO_DEPTH          (DEPTH)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .sum_in           (sum_in),
    .sum_valid_in     (sum_valid_in),
    .result_out       (result_out),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .overflow_out     (overflow_out),
    .count_out        (count_out)
  );

  // Skewed drive for cycle t of a burst of n vectors taken from vec_tab.
  task automatic drive_inputs(input int t, input int n);
    sum_valid_in = (t < n);
    for (int c = 0; c < COLS; c++) begin
      if (t - c >= 0 && t - c < n) sum_in[c] = vec_tab[t-c][c];
      else                         sum_in[c] = 16'hBEEF;
    end
  endtask

  // Runs a burst until the last vector has been written; ready pulses at ready_cyc.
  task automatic stream(input int n, input int ready_cyc);
    for (int t = 0; t < n + COLS - 1; t++) begin
      @(negedge clk);
      drive_inputs(t, n);
      result_ready_in = (t == ready_cyc);
    end
    @(negedge clk);
    sum_valid_in    = 1'b0;
    sum_in          = '0;
    result_ready_in = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    sum_valid_in = 1'b0;
    sum_in = '0;
    result_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (result_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", result_valid_out); end
    n_checks++;
    if (count_out !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_out); end
    n_checks++;
    if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow_out); end
    n_checks++;
    if (result_out !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", result_out); end
    rst_in = 1'b0;
  endtask

  task automatic test_single_vector();
    vec_t exp_v;
    for (int c = 0; c < COLS; c++) begin
      vec_tab[0][c] = 16'(100 + c);
      exp_v[c]      = 16'(100 + c);
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      n_checks++;
      if (result_valid_out !== (t >= 8)) begin
        n_fail++; $display("FAIL single_valid_t%0d got %b want %b", t, result_valid_out, (t >= 8));
      end
      if (t == 8) begin
        n_checks++;
        if (result_out !== exp_v) begin n_fail++; $display("FAIL single_data got %h want %h", result_out, exp_v); end
        n_checks++;
        if (count_out !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count_out); end
      end
      drive_inputs(t, 1);
    end
    sum_valid_in = 1'b0;
    result_ready_in = 1'b1;
    @(negedge clk);
    result_ready_in = 1'b0;
    n_checks++;
    if (count_out !== 3'd0 || result_valid_out !== 1'b0) begin
      n_fail++; $display("FAIL single_drain count %0d valid %b want 0 0", count_out, result_valid_out);
    end
    // Pop while empty must be ignored.
    result_ready_in = 1'b1;
    @(negedge clk);
    result_ready_in = 1'b0;
    n_checks++;
    if (count_out !== 3'd0) begin n_fail++; $display("FAIL empty_pop_count got %0d want 0", count_out); end
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 4; v++)
      for (int c = 0; c < COLS; c++) vec_tab[v][c] = 16'(16'h0200 + v * 16 + c);
    stream(4, -1);
    n_checks++;
    if (count_out !== 3'd4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", count_out); end
    n_checks++;
    if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got %b want 0", overflow_out); end
    // Head must hold steady while not being consumed.
    @(negedge clk);
    n_checks++;
    if (result_out !== vec_tab[0]) begin n_fail++; $display("FAIL b2b_hold got %h want %h", result_out, vec_tab[0]); end
    for (int v = 0; v < 4; v++) begin
      n_checks++;
      if (result_valid_out !== 1'b1 || result_out !== vec_tab[v]) begin
        n_fail++; $display("FAIL b2b_read%0d valid %b data %h want 1 %h", v, result_valid_out, result_out, vec_tab[v]);
      end
      result_ready_in = 1'b1;
      @(negedge clk);
    end
    result_ready_in = 1'b0;
    n_checks++;
    if (result_valid_out !== 1'b0 || count_out !== 3'd0 || result_out !== '0) begin
      n_fail++; $display("FAIL b2b_empty valid %b count %0d data %h want 0 0 0", result_valid_out, count_out, result_out);
    end
  endtask

  task automatic test_overflow();
    for (int v = 0; v < 5; v++)
      for (int c = 0; c < COLS; c++) vec_tab[v][c] = 16'(16'h0300 + v * 16 + c);
    stream(5, -1);
    n_checks++;
    if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow_out); end
    n_checks++;
    if (count_out !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d want 4", count_out); end
    for (int v = 0; v < 4; v++) begin
      n_checks++;
      if (result_valid_out !== 1'b1 || result_out !== vec_tab[v]) begin
        n_fail++; $display("FAIL ovf_read%0d valid %b data %h want 1 %h", v, result_valid_out, result_out, vec_tab[v]);
      end
      result_ready_in = 1'b1;
      @(negedge clk);
    end
    result_ready_in = 1'b0;
    n_checks++;
    if (overflow_out !== 1'b1 || count_out !== 3'd0) begin
      n_fail++; $display("FAIL ovf_sticky flag %b count %0d want 1 0", overflow_out, count_out);
    end
    pulse_reset();
    n_checks++;
    if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow_out); end
  endtask

  task automatic test_full_pop();
    for (int v = 0; v < 4; v++)
      for (int c = 0; c < COLS; c++) vec_tab[v][c] = 16'(16'h0400 + v * 16 + c);
    stream(4, -1);
    exp_q[0] = vec_tab[1];
    exp_q[1] = vec_tab[2];
    exp_q[2] = vec_tab[3];
    for (int c = 0; c < COLS; c++) vec_tab[0][c] = 16'(16'h0500 + c);
    exp_q[3] = vec_tab[0];
    // The pop lands on the same edge as the push of the new vector.
    stream(1, COLS - 1);
    n_checks++;
    if (count_out !== 3'd4) begin n_fail++; $display("FAIL fullpop_count got %0d want 4", count_out); end
    n_checks++;
    if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow got %b want 0", overflow_out); end
    for (int v = 0; v < 4; v++) begin
      n_checks++;
      if (result_valid_out !== 1'b1 || result_out !== exp_q[v]) begin
        n_fail++; $display("FAIL fullpop_read%0d valid %b data %h want 1 %h", v, result_valid_out, result_out, exp_q[v]);
      end
      result_ready_in = 1'b1;
      @(negedge clk);
    end
    result_ready_in = 1'b0;
  endtask

  task automatic test_relu();
    vec_t exp_v;
    for (int c = 0; c < COLS; c++) vec_tab[0][c] = 16'(c);
    vec_tab[0][0] = 16'hFF00;
    vec_tab[0][1] = 16'h0400;
    vec_tab[0][COLS-1] = 16'h8001;
    exp_v = vec_tab[0];
`ifdef SYSTOLIC_RELU_EN
    exp_v[0] = 16'h0000;
    exp_v[COLS-1] = 16'h0000;
`endif
    stream(1, -1);
    n_checks++;
    if (result_valid_out !== 1'b1 || result_out !== exp_v) begin
      n_fail++; $display("FAIL relu_data valid %b data %h want 1 %h", result_valid_out, result_out, exp_v);
    end
    n_checks++;
    if (fixed_t'(result_out[1]) !== fixed_t'(16'h0400)) begin
      n_fail++; $display("FAIL relu_positive got %h want 0400", result_out[1]);
    end
    result_ready_in = 1'b1;
    @(negedge clk);
    result_ready_in = 1'b0;
  endtask

  task automatic test_reset_midflight();
    bit seen_valid;
    for (int c = 0; c < COLS; c++) vec_tab[0][c] = 16'(16'h0600 + c);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      drive_inputs(t, 1);
    end
    #2 rst_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b0;
    seen_valid = 1'b0;
    for (int t = 0; t < 12; t++) begin
      drive_inputs(t + 4, 1);
      @(negedge clk);
      if (result_valid_out !== 1'b0) seen_valid = 1'b1;
    end
    sum_valid_in = 1'b0;
    n_checks++;
    if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL midflight_valid got 1 want 0"); end
    n_checks++;
    if (count_out !== 3'd0) begin n_fail++; $display("FAIL midflight_count got %0d want 0", count_out); end
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_relu();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
